// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: instruction memory address/data, decode queue handshake
// and the branch redirect request.
interface fetch_ctrl_if;
    logic [31:0] imem_pc;
    logic [39:0] imem_instr;
    logic        fq_valid;
    logic [39:0] fq_instr;
    logic [31:0] fq_pc;
    logic        fq_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_pc,
        input  imem_instr,
        output fq_valid,
        output fq_instr,
        output fq_pc,
        input  fq_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        input  fq_valid,
        input  fq_instr,
        input  fq_pc,
        output fq_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, buffers {pc, instr} in a small FIFO
// for decode, and handles redirect flush, HALT opcode and out-of-range fetch.
//
//   state  | meaning
//   S_RUN  | fetching one instruction per cycle when the queue has space
//   S_HALT | a HALT opcode has been queued; fetch stopped until redirect
//   S_ERR  | fetch PC ran past the end of memory; stopped until redirect
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          INSTR_BYTES = 5,
    parameter int          MEM_BYTES   = 512,
    parameter int          DEPTH       = 2,
    parameter logic [7:0]  HALT_OPCODE = 8'hF4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus,
    output logic         halted,
    output logic         fetch_err,
    output logic [15:0]  fetch_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_RUN, S_HALT, S_ERR} state_t;

    state_t          state_q;
    logic [31:0]     fetch_pc_q;
    logic [39:0]     instr_q [DEPTH];
    logic [31:0]     pc_q    [DEPTH];
    logic [PW-1:0]   rd_q;
    logic [PW-1:0]   wr_q;
    logic [CW-1:0]   count_q;
    logic            halted_q;
    logic            err_q;
    logic [15:0]     fcnt_q;

    logic            pop;
    logic            space;
    logic            oob;
    logic            push;
    logic            halt_hit;

    always_comb begin
        pop      = (count_q != '0) && bus.fq_ready && !bus.redirect_valid;
        space    = (count_q < CW'(DEPTH)) || pop;
        // 33-bit compare so a PC near 2^32 can never wrap back into range
        oob      = {1'b0, fetch_pc_q} > 33'(MEM_BYTES - INSTR_BYTES);
        push     = !bus.redirect_valid && (state_q == S_RUN) && !oob && space;
        halt_hit = (bus.imem_instr[7:0] == HALT_OPCODE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            fetch_pc_q <= RESET_PC;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
            fcnt_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (bus.redirect_valid) begin
            state_q    <= S_RUN;
            halted_q   <= 1'b0;
            fetch_pc_q <= bus.redirect_pc;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
        end else begin
            if (state_q == S_RUN && oob) begin
                state_q  <= S_ERR;
                halted_q <= 1'b1;
                err_q    <= 1'b1;
            end else if (push) begin
                instr_q[wr_q] <= bus.imem_instr;
                pc_q[wr_q]    <= fetch_pc_q;
                wr_q          <= wr_q + PW'(1);
                fetch_pc_q    <= fetch_pc_q + 32'(INSTR_BYTES);
                fcnt_q        <= fcnt_q + 16'd1;
                if (halt_hit) begin
                    state_q  <= S_HALT;
                    halted_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign bus.imem_pc  = fetch_pc_q;
    assign bus.fq_valid = (count_q != '0);
    assign bus.fq_instr = instr_q[rd_q];
    assign bus.fq_pc    = pc_q[rd_q];
    assign halted       = halted_q;
    assign fetch_err    = err_q;
    assign fetch_count  = fcnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, async reset sequence, and
// random redirect/backpressure traffic against a queue-based reference model.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted;
    logic        fetch_err;
    logic [15:0] fetch_count;

    fetch_ctrl_if bus();

    fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .halted     (halted),
        .fetch_err  (fetch_err),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [512];

    always_comb begin
        bus.imem_instr = '0;
        for (int k = 0; k < 5; k++) begin
            if (longint'(bus.imem_pc) + k < 512)
                bus.imem_instr[8*k +: 8] = mem[int'(bus.imem_pc) + k];
        end
    end

    int checks = 0;
    int errors = 0;

    function automatic logic [39:0] word(input logic [31:0] pc);
        logic [39:0] w = '0;
        for (int k = 0; k < 5; k++)
            if (longint'(pc) + k < 512) w[8*k +: 8] = mem[int'(pc) + k];
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [31:0] epc,
                                 input logic [39:0] einstr, input logic [31:0] eimem,
                                 input logic eh, input logic ee, input logic [15:0] ec);
        chk({tag, ".fq_valid"}, 64'(bus.fq_valid), 64'(ev));
        if (ev) begin
            chk({tag, ".fq_pc"}, 64'(bus.fq_pc), 64'(epc));
            chk({tag, ".fq_instr"}, 64'(bus.fq_instr), 64'(einstr));
        end
        chk({tag, ".imem_pc"}, 64'(bus.imem_pc), 64'(eimem));
        chk({tag, ".halted"}, 64'(halted), 64'(eh));
        chk({tag, ".fetch_err"}, 64'(fetch_err), 64'(ee));
        chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(ec));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".fq_valid"}, 64'(bus.fq_valid), 64'd0);
        chk({tag, ".fq_pc"}, 64'(bus.fq_pc), 64'd0);
        chk({tag, ".fq_instr"}, 64'(bus.fq_instr), 64'd0);
        chk({tag, ".imem_pc"}, 64'(bus.imem_pc), 64'd0);
        chk({tag, ".halted"}, 64'(halted), 64'd0);
        chk({tag, ".fetch_err"}, 64'(fetch_err), 64'd0);
        chk({tag, ".fetch_count"}, 64'(fetch_count), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.fq_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed vectors: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eimem;
        logic        eh;
        logic        ee;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic ev, input logic [31:0] epc, input logic [31:0] eimem,
                                input logic eh, input logic ee, input logic [15:0] ec);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc;
        v.eimem = eimem; v.eh = eh; v.ee = ee; v.ec = ec;
        return v;
    endfunction

    // Reference model: decode queue as SV queues, state as a small integer.
    logic [31:0] m_qpc [$];
    logic [39:0] m_qin [$];
    logic [31:0] m_pc;
    int          m_state;   // 0 running, 1 halted on opcode, 2 out of range
    logic        m_err;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_qpc.delete();
        m_qin.delete();
        m_pc = 32'h0;
        m_state = 0;
        m_err = 1'b0;
        m_cnt = '0;
    endtask

    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [39:0] w;
        if (rv) begin
            m_qpc.delete();
            m_qin.delete();
            m_pc = rpc;
            m_state = 0;
        end else begin
            if (m_qpc.size() > 0 && rdy) begin
                void'(m_qpc.pop_front());
                void'(m_qin.pop_front());
            end
            if (m_state == 0) begin
                if (longint'(m_pc) > 512 - 5) begin
                    m_state = 2;
                    m_err = 1'b1;
                end else if (m_qpc.size() < 2) begin
                    w = word(m_pc);
                    m_qpc.push_back(m_pc);
                    m_qin.push_back(w);
                    m_pc = m_pc + 32'd5;
                    m_cnt = m_cnt + 16'd1;
                    if (w[7:0] == 8'hF4) m_state = 1;
                end
            end
        end
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.fq_ready = 1'b0;

        // Directed: NOPs everywhere, HALT opcode at address 15.
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[15] = 8'hF4;

        tbl[0]  = mk(0, 0,   0, 1, 0,   5,   0, 0, 1);
        tbl[1]  = mk(0, 0,   0, 1, 0,   10,  0, 0, 2);
        tbl[2]  = mk(0, 0,   0, 1, 0,   10,  0, 0, 2);
        tbl[3]  = mk(0, 0,   0, 1, 0,   10,  0, 0, 2);
        tbl[4]  = mk(0, 0,   1, 1, 5,   15,  0, 0, 3);
        tbl[5]  = mk(0, 0,   1, 1, 10,  20,  1, 0, 4);
        tbl[6]  = mk(0, 0,   1, 1, 15,  20,  1, 0, 4);
        tbl[7]  = mk(0, 0,   1, 0, 0,   20,  1, 0, 4);
        tbl[8]  = mk(1, 100, 1, 0, 0,   100, 0, 0, 4);
        tbl[9]  = mk(0, 0,   0, 1, 100, 105, 0, 0, 5);
        tbl[10] = mk(0, 0,   0, 1, 100, 110, 0, 0, 6);
        tbl[11] = mk(1, 508, 1, 0, 0,   508, 0, 0, 6);
        tbl[12] = mk(0, 0,   1, 0, 0,   508, 1, 1, 6);
        tbl[13] = mk(0, 0,   1, 0, 0,   508, 1, 1, 6);
        tbl[14] = mk(1, 507, 1, 0, 0,   507, 0, 1, 6);
        tbl[15] = mk(0, 0,   0, 1, 507, 512, 0, 1, 7);
        tbl[16] = mk(0, 0,   0, 1, 507, 512, 1, 1, 7);
        tbl[17] = mk(0, 0,   1, 0, 0,   512, 1, 1, 7);
        tbl[18] = mk(1, 0,   1, 0, 0,   0,   0, 1, 7);
        tbl[19] = mk(0, 0,   1, 1, 0,   5,   0, 1, 8);
        tbl[20] = mk(0, 0,   1, 1, 5,   10,  0, 1, 9);
        tbl[21] = mk(0, 0,   1, 1, 10,  15,  0, 1, 10);
        tbl[22] = mk(0, 0,   1, 1, 15,  20,  1, 1, 11);
        tbl[23] = mk(1, 40,  1, 0, 0,   40,  0, 1, 11);

        do_reset();
        for (int r = 0; r < 24; r++) begin
            bus.redirect_valid = tbl[r].rv;
            bus.redirect_pc    = tbl[r].rpc;
            bus.fq_ready       = tbl[r].rdy;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", r), tbl[r].ev, tbl[r].epc, word(tbl[r].epc),
                          tbl[r].eimem, tbl[r].eh, tbl[r].ee, tbl[r].ec);
        end

        // Random: sprinkled HALT opcodes, random redirects and backpressure.
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 512; i += 5) if ($urandom_range(0, 11) == 0) mem[i] = 8'hF4;
        for (int i = 0; i < 512; i += 5) if (mem[i] == 8'hF4 && i < 60) mem[i] = 8'h90;

        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        rv;
            logic [31:0] rpc;
            logic        rdy;
            int          sel;
            rv  = ($urandom_range(0, 9) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       rpc = 32'($urandom_range(0, 103) * 5);
            else if (sel < 9)  rpc = 32'($urandom_range(0, 520));
            else               rpc = 32'hFFFF_FFFB + 32'($urandom_range(0, 4));
            rdy = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = rv;
            bus.redirect_pc    = rpc;
            bus.fq_ready       = rdy;
            model_step(rv, rpc, rdy);
            @(posedge clk);
            #1;
            check_outputs("rand", m_qpc.size() > 0,
                          (m_qpc.size() > 0) ? m_qpc[0] : 32'h0,
                          (m_qin.size() > 0) ? m_qin[0] : 40'h0,
                          m_pc, m_state != 0, m_err, m_cnt);
        end

        // Async reset between edges while streaming, then restart from RESET_PC.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd0;
        bus.fq_ready       = 1'b1;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_rst.fq_valid", 64'(bus.fq_valid), 64'd1);
        chk("after_rst.fq_pc", 64'(bus.fq_pc), 64'd0);
        chk("after_rst.fetch_count", 64'(fetch_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer for the 5-byte little-endian instruction memory. It owns the fetch PC and drives the memory's combinational address port. Each returned instruction is buffered with its PC in a small FIFO and handed to decode over a valid/ready handshake. It also handles branch redirects with a flush, halts on the HALT opcode, and flags fetches that would run past the end of memory.

Parameters:
RESET_PC, 32'h0, fetch PC after reset
INSTR_BYTES, 5, PC increment per instruction (fixed-length fetch)
MEM_BYTES, 512, instruction memory size in bytes (used for the bounds check)
DEPTH, 2, fetch-queue entries; power of 2, minimum 2
HALT_OPCODE, 8'hF4, opcode byte (instr[7:0]) that stops fetch

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
imem_pc  output  32  address to instruction memory; equals fetch_pc (combinational)
imem_instr  input  40  instruction bytes returned combinationally for imem_pc
fq_valid  output  1  queue head is valid
fq_instr  output  40  queue head instruction
fq_pc  output  32  PC of the queue head
fq_ready  input  1  decode accepts the head this cycle
redirect_valid  input  1  branch/jump redirect request
redirect_pc  input  32  redirect target
halted  output  1  fetch stopped (HALT or ERR state)
fetch_err  output  1  sticky; a fetch was attempted beyond memory
fetch_count  output  16  instructions pushed since reset; wraps

Behaviour:
- Reset (rst_n=0, asynchronous):
  - fetch_pc=RESET_PC, queue empty, state=RUN.
  - fq_valid=0, fq_instr=0, fq_pc=0, halted=0, fetch_err=0, fetch_count=0.
- States:
  - RUN: fetching.
  - HALT: a HALT opcode has been queued.
  - ERR: out-of-bounds PC.
  - halted=1 in HALT and ERR.
- pop = fq_valid & fq_ready & ~redirect_valid. The head advances next cycle.
- space = (count<DEPTH) | pop. A full queue with a simultaneous pop still accepts a push.
- Bounds check: oob = (fetch_pc > MEM_BYTES-INSTR_BYTES). Use a 33-bit compare; no wrap.
- Priority each cycle, highest first:
  1. redirect_valid:
     - Flush the queue (count=0); this cycle's fq_ready is ignored.
     - fetch_pc<=redirect_pc; state<=RUN from any state.
     - No push. fetch_err stays sticky.
  2. state RUN & oob: no push, state<=ERR, fetch_err<=1.
  3. state RUN & space:
     - Push {fetch_pc, imem_instr}; fetch_pc<=fetch_pc+INSTR_BYTES (32-bit wrap); fetch_count+=1.
     - If imem_instr[7:0]==HALT_OPCODE, state<=HALT after the push; the HALT instruction itself is queued.
  4. Otherwise fetch_pc holds (stall when full, or when halted).
- Pop applies in the same cycle as a push. Count changes by push-pop.
- Latency and throughput:
  - An instruction at fetch_pc is visible on fq_* one cycle after its push edge.
  - Sustained throughput is 1 instr/cycle with fq_ready held high.
- Queue outputs:
  - Registered storage; fq_* reflect the head entry.
  - fq_instr and fq_pc hold their last value when empty (don't-care, but must not be X after reset).
  - Ordering is strict FIFO; pointers wrap mod DEPTH.
- In HALT/ERR the queue keeps draining to decode normally.
- Reset mid-operation discards all entries immediately and returns to the reset state.

Test Plan:
1. Streaming: reset, memory holds NOPs at 0,5,10..., fq_ready=1 → fq_pc = 0,5,10,15 on consecutive cycles starting 1 cycle after reset release; fetch_count increments every cycle.
2. Backpressure: fq_ready=0 for 6 cycles, DEPTH=2 → exactly 2 entries (pc 0,5) queued, imem_pc stalls at 10. Raise fq_ready → pc 0,5,10 delivered in order with no bubble or duplicate.
3. Redirect: redirect_valid=1, redirect_pc=100, with 2 entries queued and fq_ready=1 → next cycle queue empty and fq_valid=0; next pushed fq_pc=100, then 105. Redirect while HALT → state RUN, halted=0.
4. Halt: byte F4 at address 15 → entries 0,5,10,15 delivered, halted=1 after the push of 15, imem_pc frozen at 20, fetch_count=4.
5. Bounds: redirect_pc=508 (MEM_BYTES=512) → no push, halted=1, fetch_err=1. Redirect to 0 → fetch resumes, fetch_err stays 1. redirect_pc=507 → one push, then ERR at 512.
6. Async reset: assert rst_n=0 mid-stream between clock edges → all outputs at reset values immediately. Release → first fq_pc=RESET_PC.
